// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: mode/buffer encodings and the width-generic immediate extension function.
package imm_ext_pkg;
  localparam int EXT_MAX_W = 64;
  localparam logic [1:0] MODE_SIGN = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;
  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_e;
  // Computed at EXT_MAX_W; callers truncate to their output width.
  function automatic logic [EXT_MAX_W-1:0] ext_calc(input logic [EXT_MAX_W-1:0] imm, input logic [1:0] mode,
                                                    input int in_w, input int br_shift);
    logic [EXT_MAX_W-1:0] m, h, z, s;
    m = (64'd1 << in_w) - 64'd1;
    h = 64'd1 << (in_w - 1);
    z = imm & m;
    s = (z ^ h) - h;
    return mode == MODE_SIGN ? s : mode == MODE_ZERO ? z : mode == MODE_UPPER ? z << in_w : s << br_shift;
  endfunction
endpackage

// File: rtl/imm_ext_skid.sv
// imm_ext_skid: 2-entry FIFO skid buffer; in_ready is a registered not-full, gated by reset.
module imm_ext_skid
  import imm_ext_pkg::*;
#(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  buf_state_e state_q, state_d;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic nf_q, nf_d, acc, drn;
  assign in_ready = !reset && nf_q;
  assign out_valid = state_q != BUF_EMPTY;
  assign out_data = e0_q;
  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    e0_d = e0_q;
    e1_d = e1_q;
    case (state_q)
      BUF_EMPTY: if (acc) begin
        state_d = BUF_ONE;
        e0_d = in_data;
      end
      BUF_ONE: if (acc && !drn) begin
        state_d = BUF_FULL;
        e1_d = in_data;
      end else if (acc) e0_d = in_data;
      else if (drn) state_d = BUF_EMPTY;
      BUF_FULL: if (drn) begin
        state_d = BUF_ONE;
        e0_d = e1_q;
      end
      default: state_d = BUF_EMPTY;
    endcase
    nf_d = state_d != BUF_FULL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      e0_q <= '0;
      e1_q <= '0;
      nf_q <= 1'b1;
    end else begin
      state_q <= state_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
      nf_q <= nf_d;
    end
  end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate extension behind a skid buffer; IMM_EXT_COUNT_EN enables ext_count.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int OUT_W = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      ext_count
);
  if (OUT_W < 2 * IN_W || OUT_W > EXT_MAX_W) begin : g_bad_width
    $error("imm_extend_pipe: OUT_W must be >= 2*IN_W and <= %0d", EXT_MAX_W);
  end
  logic [OUT_W-1:0] ext;
  logic [OUT_W+TAG_W-1:0] out_data;
  assign ext = OUT_W'(ext_calc(EXT_MAX_W'(in_imm), in_mode, IN_W, BR_SHIFT));
  assign {out_imm, out_tag} = out_data;
  imm_ext_skid #(.W(OUT_W + TAG_W)) u_skid (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data({ext, in_tag}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );
`ifdef IMM_EXT_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (out_valid && out_ready) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign ext_count = cnt_q;
`else
  assign ext_count = '0;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: randomized + directed checks of imm_extend_pipe against a queue-based reference model.
module tb_imm_extend_pipe;
  localparam int IN_W = 16, OUT_W = 32, BR_SHIFT = 2, TAG_W = 5;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, in_ready, out_valid;
  logic [IN_W-1:0] in_imm = '0;
  logic [1:0] in_mode = '0;
  logic [TAG_W-1:0] in_tag = '0, out_tag, hold_tag;
  logic [OUT_W-1:0] out_imm, hold_imm, last_out;
  logic [15:0] ext_count, exp_cnt;
  logic [OUT_W+TAG_W-1:0] q[$];
  int n_cmp = 0, n_bad = 0, drains = 0;
  logic stall = 0, got_out = 0;
  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .ext_count(ext_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] imm, input logic [1:0] mode);
    longint u, s, r;
    u = longint'(imm);
    s = (u >= (longint'(1) << (IN_W - 1))) ? u - (longint'(1) << IN_W) : u;
    r = mode == 2'd0 ? s : mode == 2'd1 ? u : mode == 2'd2 ? u * (longint'(1) << IN_W) : s * (longint'(1) << BR_SHIFT);
    return OUT_W'(r);
  endfunction
  task automatic cycle(input logic v, input logic [IN_W-1:0] imm, input logic [1:0] mode,
                       input logic [TAG_W-1:0] tag, input logic ordy);
    logic [OUT_W+TAG_W-1:0] e;
    @(negedge clk);
    chk("ext_count", 64'(ext_count), 64'(exp_cnt));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (stall) begin
      chk("hold_imm", 64'(out_imm), 64'(hold_imm));
      chk("hold_tag", 64'(out_tag), 64'(hold_tag));
    end
    in_valid = v; in_imm = imm; in_mode = mode; in_tag = tag; out_ready = ordy;
    #1;
    got_out = 0;
    stall = out_valid && !out_ready;
    hold_imm = out_imm;
    hold_tag = out_tag;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious", 64'(out_valid), 64'(0));
      else begin
        e = q.pop_front();
        chk("out_imm", 64'(out_imm), 64'(e[OUT_W+TAG_W-1:TAG_W]));
        chk("out_tag", 64'(out_tag), 64'(e[TAG_W-1:0]));
      end
      last_out = out_imm;
      got_out = 1;
      drains++;
`ifdef IMM_EXT_COUNT_EN
      exp_cnt = 16'(drains);
`else
      exp_cnt = 16'd0;
`endif
    end
    if (in_valid && in_ready) q.push_back({ref_ext(imm, mode), tag});
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1; in_valid = 0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_imm", 64'(out_imm), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_ext_count", 64'(ext_count), 64'(0));
    reset = 0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'(1));
    q.delete();
    drains = 0; exp_cnt = 0; stall = 0;
  endtask
  task automatic directed(input string tag, input logic [IN_W-1:0] imm, input logic [1:0] mode,
                          input logic [TAG_W-1:0] t, input logic [OUT_W-1:0] exp);
    cycle(1, imm, mode, t, 1);
    cycle(0, '0, '0, '0, 1);
    chk({tag, "_lat"}, 64'(got_out), 64'(1));
    chk(tag, 64'(last_out), 64'(exp));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    do_reset();
    cycle(1, 16'h8001, 2'd0, 5'd3, 1);
    cycle(0, '0, '0, '0, 1);
    chk("sign_tag", 64'(out_tag), 64'(3));
    chk("sign_neg", 64'(last_out), 64'h0000_0000_FFFF_8001);
    directed("sign_pos", 16'h7FFF, 2'd0, 5'd1, 32'h0000_7FFF);
    directed("zero", 16'h8001, 2'd1, 5'd2, 32'h0000_8001);
    directed("upper", 16'h1234, 2'd2, 5'd4, 32'h1234_0000);
    directed("branch_neg", 16'hFFFF, 2'd3, 5'd5, 32'hFFFF_FFFC);
    directed("branch_pos", 16'h4000, 2'd3, 5'd6, 32'h0001_0000);
    // Back-pressure: A and B fill the buffer, C must be held off until a drain.
    cycle(1, 16'h0001, 2'd1, 5'd10, 0);
    cycle(1, 16'h0002, 2'd1, 5'd11, 0);
    cycle(1, 16'h0003, 2'd1, 5'd12, 0);
    chk("bp_full", 64'(in_ready), 64'(0));
    cycle(1, 16'h0003, 2'd1, 5'd12, 0);
    chk("bp_head", 64'(out_imm), 64'(1));
    for (int i = 0; i < 8 && q.size() != 0; i++) cycle(q.size() < 3 && i < 2, 16'h0003, 2'd1, 5'd12, 1);
    chk("bp_order", 64'(last_out), 64'(3));
    for (int i = 0; i < 8; i++) cycle(1, 16'($urandom), 2'($urandom), 5'($urandom), 1);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, '0, 1);
    // Reset while FULL: nothing stale may ever appear afterwards.
    cycle(1, 16'hAAAA, 2'd0, 5'd7, 0);
    cycle(1, 16'hBBBB, 2'd0, 5'd8, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, '0, 1);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom), 5'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, '0, 1);
`ifdef IMM_EXT_COUNT_EN
    do_reset();
    for (int i = 0; i < 66000 && drains < 65537; i++) cycle(1, 16'($urandom), 2'($urandom), 5'($urandom), 1);
    chk("wrap_drains", 64'(drains), 64'(65537));
    cycle(0, '0, '0, '0, 0);
    chk("wrap", 64'(ext_count), 64'(1));
`else
    chk("cnt_off", 64'(ext_count), 64'(0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
